apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
// - Upstream APB requester: turns single-beat cmd handshakes from the local bus into APB3
//   SETUP/ACCESS transfers driving the APB slave (PSEL/PENABLE/PWRITE/PADDR/PWDATA -> PRDATA/PREADY).
// - Returns read data or a timeout error on a one-cycle response strobe. One slave, one outstanding transfer.
// PARAMETERS
// - ADDR_WIDTH  8   PADDR / cmd_addr width
// - DATA_WIDTH  16  PWDATA / PRDATA / cmd_wdata / rsp_rdata width
// - TIMEOUT     16  max ACCESS cycles waiting for PREADY; 0 = wait forever
// PORTS
// - PCLK       in   1           clock; all logic on rising edge
// - PRESET     in   1           reset, synchronous, active-high
// - cmd_valid  in   1           request present
// - cmd_ready  out  1           bridge accepts request this cycle
// - cmd_write  in   1           1 = write, 0 = read
// - cmd_addr   in   ADDR_WIDTH  target address
// - cmd_wdata  in   DATA_WIDTH  write data (ignored for reads)
// - rsp_valid  out  1           one-cycle completion pulse; no backpressure
// - rsp_rdata  out  DATA_WIDTH  PRDATA captured on read completion; 0 for writes/errors
// - rsp_err    out  1           1 = transfer timed out (valid with rsp_valid)
// - PSEL       out  1           APB select
// - PENABLE    out  1           APB enable (ACCESS phase)
// - PWRITE     out  1           APB direction
// - PADDR      out  ADDR_WIDTH  APB address
// - PWDATA     out  DATA_WIDTH  APB write data
// - PRDATA     in   DATA_WIDTH  APB read data
// - PREADY     in   1           APB slave ready
// BEHAVIOUR
// - Reset (PRESET=1 at edge): state=IDLE; PSEL,PENABLE,PWRITE,PADDR,PWDATA,rsp_valid,rsp_rdata,rsp_err=0; counter=0.
// - All outputs registered except cmd_ready = (state==IDLE) & ~PRESET.
// - FSM IDLE/SETUP/ACCESS:
//   IDLE:   cmd_valid&cmd_ready -> latch cmd into PWRITE/PADDR/PWDATA, PSEL=1, PENABLE=0, -> SETUP.
//   SETUP:  unconditional -> ACCESS, PENABLE=1; addr/data/dir held stable; counter cleared.
//   ACCESS: PREADY=1 -> PSEL=PENABLE=0, rsp_valid=1, rsp_err=0, rsp_rdata=PWRITE?0:PRDATA, -> IDLE.
//           PREADY=0 & TIMEOUT!=0 & counter==TIMEOUT-1 -> drop PSEL/PENABLE, rsp_valid=1, rsp_err=1,
//           rsp_rdata=0, -> IDLE. Otherwise counter+1, stay (wait states).
// - Latency: accept at edge N -> SETUP N+1, ACCESS N+2; PREADY high at N+2 -> rsp_valid high in cycle N+3.
// - Back-to-back: cmd_ready is high in the rsp_valid cycle; next SETUP follows immediately; min 3 cycles/transfer.
// - rsp_valid is a single-cycle pulse; rsp_rdata/rsp_err hold until next completion (cleared only by reset).
// - PADDR/PWDATA/PWRITE keep last values in IDLE (no toggling); PENABLE never high without PSEL.
// - PREADY/PRDATA ignored outside ACCESS. cmd_valid while busy ignored (not accepted, cmd_ready=0).
// - Timeout counter width clog2(TIMEOUT)+1; saturation impossible since exit at TIMEOUT-1.
// - TIMEOUT=1: ACCESS lasts exactly one cycle; no PREADY in it -> error.
// - Reset mid-transfer: abort; PSEL/PENABLE low after that edge; no rsp_valid for the aborted cmd.
// STRUCTURE
// - Shared include apb_defs.vh: state encodings (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2), APB
//   phase constants; reused by APB_Slave and future decoders.
// - Single module; timeout counter inline. Optional sub-module apb_timeout_ctr only if reused.
// TESTING (bench: this block + behavioural APB slave with programmable wait states)
// - Write 0x00<=0xFFFF, 0 waits -> PSEL 2 cycles, PENABLE 1 cycle, rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
// - Read 0x00 after above -> rsp_rdata=0xFFFF; then write 0x01<=0xEACF, read 0x01 -> 0xEACF.
// - Read with 3 wait states (PREADY low 3 ACCESS cycles) -> PADDR/PENABLE stable, rsp_valid at N+6.
// - TIMEOUT=4, slave never ready -> exactly 4 ACCESS cycles, rsp_valid=1, rsp_err=1, rsp_rdata=0.
// - Back-to-back: cmd_valid held high for 3 cmds -> accepts at N, N+3, N+6; 3 responses in order.
// - PRESET=1 in ACCESS with PREADY=0 -> next cycle PSEL=PENABLE=0, cmd_ready=1 after release, no rsp_valid.

Source files
------------

// File: rtl/apb_master_bridge_pkg.sv
// APB master bridge: shared types and defaults.
// State encoding matches the APB phase numbering.
package apb_master_bridge_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_TIMEOUT    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  function automatic int cnt_width(
    input int unsigned t
  );
    return $clog2(t) + 1;
  endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Local command/response bus and APB3 bus.
// master drives the request, slave answers it.
interface apb_cmd_if
  import apb_master_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output cmd_valid, cmd_write,
    output cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_write,
    input  cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err
  );
endinterface

interface apb_bus_if
  import apb_master_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;

  modport master (
    output PSEL, PENABLE, PWRITE,
    output PADDR, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE,
    input  PADDR, PWDATA,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 requester with
// optional ACCESS-phase timeout.
module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic      PCLK,
  input  logic      PRESET,
  apb_cmd_if.slave  cmd,
  apb_bus_if.master apb
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LAST =
    CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          timed_out;

  assign cmd.cmd_ready =
    (state == IDLE) & ~PRESET;

  // Kept exclusive with PREADY so the
  // ACCESS decode stays one-hot.
  assign timed_out = ~apb.PREADY
    & (TIMEOUT != 0) & (cnt == LAST);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state         <= IDLE;
      cnt           <= '0;
      apb.PSEL      <= 1'b0;
      apb.PENABLE   <= 1'b0;
      apb.PWRITE    <= 1'b0;
      apb.PADDR     <= '0;
      apb.PWDATA    <= '0;
      cmd.rsp_valid <= 1'b0;
      cmd.rsp_rdata <= '0;
      cmd.rsp_err   <= 1'b0;
    end else begin
      cmd.rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd.cmd_valid) begin
            apb.PWRITE  <= cmd.cmd_write;
            apb.PADDR   <= cmd.cmd_addr;
            apb.PWDATA  <= cmd.cmd_wdata;
            apb.PSEL    <= 1'b1;
            apb.PENABLE <= 1'b0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          apb.PENABLE <= 1'b1;
          cnt         <= '0;
          state       <= ACCESS;
        end
        ACCESS: begin
          unique case (1'b1)
            apb.PREADY: begin
              apb.PSEL      <= 1'b0;
              apb.PENABLE   <= 1'b0;
              cmd.rsp_valid <= 1'b1;
              cmd.rsp_err   <= 1'b0;
              cmd.rsp_rdata <= apb.PWRITE
                ? '0 : apb.PRDATA;
              state         <= IDLE;
            end
            timed_out: begin
              apb.PSEL      <= 1'b0;
              apb.PENABLE   <= 1'b0;
              cmd.rsp_valid <= 1'b1;
              cmd.rsp_err   <= 1'b1;
              cmd.rsp_rdata <= '0;
              state         <= IDLE;
            end
            default: cnt <= cnt + 1'b1;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a
// wait-state programmable APB slave model.
module tb_apb_master_bridge;

  logic PCLK = 1'b0;
  logic PRESET = 1'b1;

  always #5 PCLK = ~PCLK;

  apb_cmd_if #(8, 16) cif ();
  apb_bus_if #(8, 16) bif ();

  apb_master_bridge #(.TIMEOUT(4)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .cmd    (cif),
    .apb    (bif)
  );

  // Slave model
  logic [15:0] mem [256];
  int          acc_cnt = 0;
  int          waits = 0;
  bit          never = 1'b0;

  assign bif.PREADY = bif.PSEL & bif.PENABLE
    & ~never & (acc_cnt == waits);
  assign bif.PRDATA = mem[bif.PADDR];

  always @(posedge PCLK) begin
    if (bif.PSEL && bif.PENABLE && !bif.PREADY)
      acc_cnt <= acc_cnt + 1;
    else
      acc_cnt <= 0;
    if (bif.PSEL && bif.PENABLE
        && bif.PREADY && bif.PWRITE)
      mem[bif.PADDR] <= bif.PWDATA;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               name, act, exp);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
    int          waits;
    bit          never;
    logic [15:0] rdata;
    bit          err;
    int          lat;
    int          npsel;
    int          npen;
  } vec_t;

  vec_t vt [8];

  task automatic do_xfer(input vec_t v);
    int  k;
    int  np;
    int  ne;
    bit  seen;
    bit  stable;
    np = 0;
    ne = 0;
    seen = 0;
    stable = 1;
    k = 0;
    @(negedge PCLK);
    waits = v.waits;
    never = v.never;
    cif.cmd_valid = 1'b1;
    cif.cmd_write = v.wr;
    cif.cmd_addr  = v.addr;
    cif.cmd_wdata = v.wdata;
    #1;
    chk("cmd_ready", cif.cmd_ready, 1);
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge PCLK);
      if (i == 1) cif.cmd_valid = 1'b0;
      if (bif.PSEL) np++;
      if (bif.PENABLE) ne++;
      if (bif.PENABLE && !bif.PSEL) stable = 0;
      if (bif.PSEL && (bif.PADDR != v.addr
          || bif.PWRITE != v.wr
          || (v.wr && bif.PWDATA != v.wdata)))
        stable = 0;
      if (cif.rsp_valid) begin
        seen = 1;
        k = i;
      end
    end
    chk("rsp_seen", seen, 1);
    chk("latency", k, v.lat);
    chk("rsp_rdata", cif.rsp_rdata, v.rdata);
    chk("rsp_err", cif.rsp_err, v.err);
    chk("psel_cycles", np, v.npsel);
    chk("penable_cycles", ne, v.npen);
    chk("apb_stable", stable, 1);
    @(negedge PCLK);
    chk("rsp_pulse", cif.rsp_valid, 0);
    chk("rdata_hold", cif.rsp_rdata, v.rdata);
  endtask

  int   acc_t [3];
  int   rsp_t [3];
  logic [15:0] rsp_d [3];
  bit   rsp_e [3];

  initial begin
    int  idx;
    int  nrsp;
    bit  upd;
    bit  any_rsp;
    bit          b_wr [3];
    logic [7:0]  b_ad [3];
    logic [15:0] b_wd [3];

    for (int i = 0; i < 256; i++) mem[i] = '0;
    cif.cmd_valid = 1'b0;
    cif.cmd_write = 1'b0;
    cif.cmd_addr  = '0;
    cif.cmd_wdata = '0;

    vt[0] = '{1, 8'h00, 16'hFFFF, 0, 0,
              16'h0000, 0, 3, 2, 1};
    vt[1] = '{0, 8'h00, 16'h0000, 0, 0,
              16'hFFFF, 0, 3, 2, 1};
    vt[2] = '{1, 8'h01, 16'hEACF, 0, 0,
              16'h0000, 0, 3, 2, 1};
    vt[3] = '{0, 8'h01, 16'h0000, 0, 0,
              16'hEACF, 0, 3, 2, 1};
    vt[4] = '{0, 8'h00, 16'h0000, 3, 0,
              16'hFFFF, 0, 6, 5, 4};
    vt[5] = '{0, 8'h01, 16'h0000, 0, 1,
              16'h0000, 1, 6, 5, 4};
    vt[6] = '{1, 8'h80, 16'h1234, 1, 0,
              16'h0000, 0, 4, 3, 2};
    vt[7] = '{0, 8'h80, 16'h0000, 2, 0,
              16'h1234, 0, 5, 4, 3};

    // Reset state
    @(negedge PCLK);
    @(negedge PCLK);
    chk("rst_psel", bif.PSEL, 0);
    chk("rst_penable", bif.PENABLE, 0);
    chk("rst_pwrite", bif.PWRITE, 0);
    chk("rst_paddr", bif.PADDR, 0);
    chk("rst_pwdata", bif.PWDATA, 0);
    chk("rst_rsp_valid", cif.rsp_valid, 0);
    chk("rst_rsp_rdata", cif.rsp_rdata, 0);
    chk("rst_rsp_err", cif.rsp_err, 0);
    chk("rst_cmd_ready", cif.cmd_ready, 0);
    PRESET = 1'b0;
    #1;
    chk("rel_cmd_ready", cif.cmd_ready, 1);

    foreach (vt[i]) do_xfer(vt[i]);

    // Back-to-back with cmd_valid held high
    b_wr[0] = 1; b_ad[0] = 8'h10;
    b_wd[0] = 16'hA5A5;
    b_wr[1] = 1; b_ad[1] = 8'h11;
    b_wd[1] = 16'h5A5A;
    b_wr[2] = 0; b_ad[2] = 8'h10;
    b_wd[2] = 16'h0000;
    @(negedge PCLK);
    waits = 0;
    never = 0;
    idx = 0;
    nrsp = 0;
    upd = 0;
    cif.cmd_valid = 1'b1;
    cif.cmd_write = b_wr[0];
    cif.cmd_addr  = b_ad[0];
    cif.cmd_wdata = b_wd[0];
    for (int t = 0; t < 40 && nrsp < 3; t++) begin
      if (t > 0) @(negedge PCLK);
      if (upd) begin
        upd = 0;
        if (idx < 3) begin
          cif.cmd_write = b_wr[idx];
          cif.cmd_addr  = b_ad[idx];
          cif.cmd_wdata = b_wd[idx];
        end else begin
          cif.cmd_valid = 1'b0;
        end
      end
      #1;
      if (cif.rsp_valid) begin
        rsp_t[nrsp] = t;
        rsp_d[nrsp] = cif.rsp_rdata;
        rsp_e[nrsp] = cif.rsp_err;
        nrsp++;
      end
      if (idx < 3 && cif.cmd_valid
          && cif.cmd_ready) begin
        acc_t[idx] = t;
        idx++;
        upd = 1;
      end
    end
    chk("b2b_accepts", idx, 3);
    chk("b2b_rsps", nrsp, 3);
    if (idx == 3 && nrsp == 3) begin
      chk("b2b_gap1", acc_t[1] - acc_t[0], 3);
      chk("b2b_gap2", acc_t[2] - acc_t[1], 3);
      for (int i = 0; i < 3; i++) begin
        chk("b2b_lat", rsp_t[i] - acc_t[i], 3);
        chk("b2b_err", rsp_e[i], 0);
      end
      chk("b2b_d0", rsp_d[0], 16'h0000);
      chk("b2b_d1", rsp_d[1], 16'h0000);
      chk("b2b_d2", rsp_d[2], 16'hA5A5);
    end

    // Reset while stalled in ACCESS
    @(negedge PCLK);
    @(negedge PCLK);
    never = 1;
    cif.cmd_valid = 1'b1;
    cif.cmd_write = 1'b0;
    cif.cmd_addr  = 8'h11;
    @(negedge PCLK);
    cif.cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("abort_in_access", bif.PENABLE, 1);
    PRESET = 1'b1;
    @(negedge PCLK);
    chk("abort_psel", bif.PSEL, 0);
    chk("abort_penable", bif.PENABLE, 0);
    chk("abort_rsp_valid", cif.rsp_valid, 0);
    chk("abort_rsp_rdata", cif.rsp_rdata, 0);
    chk("abort_ready_rst", cif.cmd_ready, 0);
    PRESET = 1'b0;
    never = 0;
    #1;
    chk("abort_ready_rel", cif.cmd_ready, 1);
    any_rsp = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge PCLK);
      if (cif.rsp_valid || bif.PSEL) any_rsp = 1;
    end
    chk("abort_no_rsp", any_rsp, 0);

    $display(
      "End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
